// File: rtl/jtframe_cen_meter_pkg.sv
// Shared definitions for the cen meter: FSM state encoding and the
// all-ones initial value used by the minimum-spacing accumulator.
package jtframe_cen_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEAS = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // All-ones value of width w (w <= 32); also the saturation level of a w-bit counter.
    function automatic logic [31:0] min_init(input int w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/jtframe_cen_period.sv
// Saturating pulse-to-pulse gap counter with min/max/overflow accumulators.
// The first sampled pulse only arms the counter; later pulses produce spacings.
module jtframe_cen_period
    import jtframe_cen_meter_pkg::*;
#(
    parameter int WP = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          cen,
    output logic [WP-1:0] min,
    output logic [WP-1:0] max,
    output logic          ovf,
    output logic          npulse_ge2
);

    localparam logic [WP-1:0] SAT = WP'(min_init(WP));

    logic          armed_q, armed_d;
    logic [WP-1:0] gap_q, gap_d;
    logic [WP-1:0] min_q, min_d;
    logic [WP-1:0] max_q, max_d;
    logic          ovf_q, ovf_d;
    logic          ge2_q, ge2_d;
    logic [WP-1:0] spacing;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
        armed_d = armed_q;
        gap_d   = gap_q;
        min_d   = min_q;
        max_d   = max_q;
        ovf_d   = ovf_q;
        ge2_d   = ge2_q;
        spacing = (gap_q == SAT) ? SAT : gap_q + 1'b1;

        if (clr) begin
            armed_d = 1'b0;
            gap_d   = '0;
            min_d   = SAT;
            max_d   = '0;
            ovf_d   = 1'b0;
            ge2_d   = 1'b0;
        end else if (en) begin
            if (cen) begin
                armed_d = 1'b1;
                gap_d   = '0;
                if (armed_q) begin
                    ge2_d = 1'b1;
                    if (gap_q == SAT) ovf_d = 1'b1;
                    if (spacing < min_q) min_d = spacing;
                    if (spacing > max_q) max_d = spacing;
                end
            end else if (armed_q && gap_q != SAT) begin
                gap_d = gap_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q <= 1'b0;
            gap_q   <= '0;
            min_q   <= SAT;
            max_q   <= '0;
            ovf_q   <= 1'b0;
            ge2_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            armed_q <= armed_d;
            gap_q   <= gap_d;
            min_q   <= min_d;
            max_q   <= max_d;
            ovf_q   <= ovf_d;
            ge2_q   <= ge2_d;
        end
    end

    assign min        = min_q;
    assign max        = max_q;
    assign ovf        = ovf_q;
    assign npulse_ge2 = ge2_q;

endmodule

// File: rtl/jtframe_cen_meter.sv
// Measures a cen stream over a window of m clk cycles: pulse count plus
// min/max pulse spacing, with a start/done handshake and held results.
module jtframe_cen_meter
    import jtframe_cen_meter_pkg::*;
#(
    parameter int WC = 10,
    parameter int WP = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          start,
    input  logic [WC-1:0] m,
    output logic          busy,
    output logic          done,
    output logic [WC-1:0] n,
    output logic [WP-1:0] min_per,
    output logic [WP-1:0] max_per,
    output logic          ovf
);

    state_t        state_q, state_d;
    logic [WC-1:0] win_q, win_d;
    logic [WC-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [WC-1:0] n_q, n_d;
    logic [WP-1:0] min_per_q, min_per_d;
    logic [WP-1:0] max_per_q, max_per_d;
    logic          ovf_q, ovf_d;

    logic          acc_clr, acc_en;
    logic [WP-1:0] acc_min, acc_max;
    logic          acc_ovf, acc_ge2;

    jtframe_cen_period #(.WP(WP)) u_period (
        .clk        (clk),
        .rst        (rst),
        .clr        (acc_clr),
        .en         (acc_en),
        .cen        (cen),
        .min        (acc_min),
        .max        (acc_max),
        .ovf        (acc_ovf),
        .npulse_ge2 (acc_ge2)
    );

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        n_d       = n_q;
        min_per_d = min_per_q;
        max_per_d = max_per_q;
        ovf_d     = ovf_q;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    win_d   = m;
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                    busy_d  = 1'b1;
                    state_d = (m == '0) ? ST_DONE : ST_MEAS;
                end
            end
            ST_MEAS: begin
                acc_en = 1'b1;
                win_d  = win_q - 1'b1;
                if (cen) cnt_d = cnt_q + 1'b1;
                if (win_q == WC'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                n_d       = cnt_q;
                ovf_d     = acc_ovf;
                // Fewer than two pulses means no spacing was ever measured.
                min_per_d = acc_ge2 ? acc_min : '0;
                max_per_d = acc_ge2 ? acc_max : '0;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            win_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            n_q       <= '0;
            min_per_q <= '0;
            max_per_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            n_q       <= n_d;
            min_per_q <= min_per_d;
            max_per_q <= max_per_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign n       = n_q;
    assign min_per = min_per_q;
    assign max_per = max_per_q;
    assign ovf     = ovf_q;

endmodule

// File: doc/jtframe_cen_meter.md
Name: jtframe_cen_meter

Overview:
- Measures a clock-enable stream produced by the fractional cen generator and reports the achieved ratio and jitter.
- Over a programmable window of M clk cycles it counts cen pulses (N) and tracks the minimum and maximum spacing between consecutive pulses.
- Used by debug and status logic, and by the verification bench, to confirm that a cen output matches the programmed n/m.
- Start/done handshake; results are held until the next measurement completes.

Parameters:
- WC, 10, width of the window length and the pulse count.
- WP, 8, width of the period (pulse spacing) measurements; saturating.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cen  in  1  clock-enable stream under test, one clk wide per pulse
- start  in  1  request a measurement; sampled only in IDLE
- m  in  WC  window length in clk cycles; latched when start is accepted
- busy  out  1  high while a measurement is in progress
- done  out  1  one-cycle pulse when results update
- n  out  WC  cen pulses counted in the window
- min_per  out  WP  smallest pulse-to-pulse spacing in clk cycles
- max_per  out  WP  largest pulse-to-pulse spacing in clk cycles
- ovf  out  1  at least one spacing saturated at 2^WP-1

Behaviour:
- Reset: async. State returns to IDLE. busy, done, n, min_per, max_per and ovf are all 0. All internal counters clear.
- IDLE:
  - start=1 at edge k: latch m into win, clear the accumulators, busy<=1.
  - If m!=0, go to MEAS. If m==0, go to DONE with n=0, min_per=0, max_per=0, ovf=0.
- MEAS:
  - Window samples are cen at edges k+1 .. k+m, exactly m samples.
  - A window down-counter decrements on each sample. On the m-th sample, go to DONE.
  - Pulse count: cnt increments on each sampled cen=1. cnt cannot exceed m, so no overflow is possible.
  - Spacing:
    - gap counter starts counting after the first cen pulse in the window and increments every cycle, saturating at 2^WP-1.
    - On each later cen pulse, the spacing is gap+1. If gap is already saturated, the spacing stays at 2^WP-1 and sets ovf_acc.
    - Each spacing updates min_acc (initial value all-ones) and max_acc (initial value 0). gap then restarts.
    - Pulses before the window do not count: the first in-window pulse only arms the gap counter.
- DONE (one cycle):
  - n<=cnt and ovf<=ovf_acc.
  - If fewer than 2 pulses were seen: min_per<=0 and max_per<=0. Otherwise min_per<=min_acc and max_per<=max_acc.
  - done=1 for this cycle only, busy<=0, return to IDLE.
  - Latency: outputs and done are visible after edge k+m+1.
- start while busy is ignored, and m changes during MEAS have no effect.
- start held high re-triggers a new measurement on the first IDLE cycle after DONE.
- Outputs are stable between done pulses.
- A cen pulse in the DONE or IDLE cycle is not counted.
- Reset mid-measurement: outputs are cleared immediately and no done pulse is issued.

Decomposition:
- Shared package jtframe_cen_meter_pkg holds:
  - state encoding constants ST_IDLE, ST_MEAS, ST_DONE (2-bit);
  - the MIN_INIT all-ones constant helper.
- One sub-module, jtframe_cen_period: the saturating gap counter plus min/max/ovf accumulators.
  - Inputs: clk, rst, clr, en, cen.
  - Outputs: min, max, ovf, npulse_ge2.
- The top level keeps the FSM, the window counter and the pulse counter.

Test Plan:
- Pattern source n=1/m=4 (cen every 4th cycle); start with m=100 -> done at k+101, n=25, min_per=4, max_per=4, ovf=0.
- Pattern source n=3/m=10; m=1000 -> n=300, min_per=3, max_per=4, ovf=0.
- cen tied high; m=50 -> n=50, min_per=1, max_per=1. Then cen tied low; m=50 -> n=0, min_per=0, max_per=0.
- Pulses 300 cycles apart, WP=8; m=700 -> n=3, max_per=255, min_per=255, ovf=1.
- m=0 -> done on the cycle after start with all results 0. start pulsed during MEAS -> no second done and no change to the window.
- rst asserted mid-MEAS -> busy and outputs are 0 immediately, no done. A new start then yields correct results for the n=1/m=4 pattern.
